pushbutton_debounce: RTL and testbench

PUSHBUTTON_DEBOUNCE -- requirements
Module: pushbutton_debounce

---
 rtl/pushbutton_pkg.sv | 17 +
 rtl/pushbutton_db_cell.sv | 66 ++++++
 rtl/pushbutton_debounce.sv | 64 ++++++
 tb/tb_pushbutton_debounce.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pushbutton_pkg.sv
// pushbutton_pkg: shared debounce FSM state encoding and counter sizing helper.
//   db_state_e : 2-bit per-channel debounce state
//   cnt_width  : bits needed to count 0..cycles without wrapping
package pushbutton_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } db_state_e;

   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/pushbutton_db_cell.sv
// pushbutton_db_cell: one button channel - synchronizer, debounce FSM, counter, edge pulses.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   btn_in : raw asynchronous button pin, 1 = pressed
//   level  : debounced level
//   rise   : one-cycle pulse when a 0->1 change is accepted
//   fall   : one-cycle pulse when a 1->0 change is accepted
module pushbutton_db_cell
   import pushbutton_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   db_state_e              st, st_nx;
   logic [CW-1:0]          cnt, cnt_nx, cnt_inc;

   assign s       = sync[SYNC_STAGES-1];
   assign cnt_inc = (cnt < CNT_MAX) ? cnt + CNT_ONE : cnt;

   // Counter is only meaningful in WAIT states; every other path clears it.
   always_comb begin
      st_nx  = st;
      cnt_nx = '0;
      case (st)
         STABLE_LO: if (s) begin st_nx = WAIT_HI; cnt_nx = CNT_ONE; end
         WAIT_HI:   if (!s) st_nx = STABLE_LO; else if (cnt == CNT_MAX) st_nx = STABLE_HI; else cnt_nx = cnt_inc;
         STABLE_HI: if (!s) begin st_nx = WAIT_LO; cnt_nx = CNT_ONE; end
         WAIT_LO:   if (s) st_nx = STABLE_HI; else if (cnt == CNT_MAX) st_nx = STABLE_LO; else cnt_nx = cnt_inc;
         default:   st_nx = STABLE_LO;
      endcase
   end

   // Level and pulses derive from the next state so they change on the accepting edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         st    <= STABLE_LO;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], btn_in};
         st    <= st_nx;
         cnt   <= cnt_nx;
         level <= (st_nx == STABLE_HI) || (st_nx == WAIT_LO);
         rise  <= (st == WAIT_HI) && (st_nx == STABLE_HI);
         fall  <= (st == WAIT_LO) && (st_nx == STABLE_LO);
      end
   end

endmodule

// File: rtl/pushbutton_debounce.sv
// pushbutton_debounce: NUM_BTN debounced buttons with sticky press events and optional interrupt.
//   s00_axi_aclk    : clock, rising edge
//   s00_axi_aresetn : asynchronous active-low reset
//   btn_in          : raw button pins, 1 = pressed
//   evt_clr_valid   : qualifies evt_clr for one cycle
//   evt_clr         : write-1-to-clear mask for evt_status
//   irq_mask        : per-button interrupt enable (PUSHBUTTON_IRQ_EN builds only)
//   btn_level       : debounced levels
//   btn_rise        : accepted press pulses
//   btn_fall        : accepted release pulses
//   evt_status      : sticky press-event bits
//   irq             : |(evt_status & irq_mask) registered; tied 0 unless PUSHBUTTON_IRQ_EN is defined
module pushbutton_debounce
   import pushbutton_pkg::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic               s00_axi_aclk,
   input  logic               s00_axi_aresetn,
   input  logic [NUM_BTN-1:0] btn_in,
   input  logic               evt_clr_valid,
   input  logic [NUM_BTN-1:0] evt_clr,
`ifdef PUSHBUTTON_IRQ_EN
   input  logic [NUM_BTN-1:0] irq_mask,
`endif
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_rise,
   output logic [NUM_BTN-1:0] btn_fall,
   output logic [NUM_BTN-1:0] evt_status,
   output logic               irq
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
      pushbutton_db_cell #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk   (s00_axi_aclk),
         .rst_n (s00_axi_aresetn),
         .btn_in(btn_in[i]),
         .level (btn_level[i]),
         .rise  (btn_rise[i]),
         .fall  (btn_fall[i])
      );
   end

   // Set is OR-ed after the clear so a coincident press is never lost.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) evt_status <= '0;
      else                  evt_status <= (evt_status & ~(evt_clr_valid ? evt_clr : '0)) | btn_rise;
   end

`ifdef PUSHBUTTON_IRQ_EN
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) irq <= 1'b0;
      else                  irq <= |(evt_status & irq_mask);
   end
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pushbutton_debounce.sv
// tb_pushbutton_debounce: directed table-driven bench for pushbutton_debounce (4 buttons, 2 sync stages, 4 debounce cycles).
module tb_pushbutton_debounce;

   logic       tb_ACLK = 1'b0;
   logic       rst_n;
   logic [3:0] btn_in;
   logic       evt_clr_valid;
   logic [3:0] evt_clr;
   logic [3:0] irq_mask;
   logic [3:0] btn_level, btn_rise, btn_fall, evt_status;
   logic       irq;
   int         errors = 0;
   int         checks = 0;

   always #5 tb_ACLK = ~tb_ACLK;

   pushbutton_debounce #(
      .NUM_BTN        (4),
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .s00_axi_aclk   (tb_ACLK),
      .s00_axi_aresetn(rst_n),
      .btn_in         (btn_in),
      .evt_clr_valid  (evt_clr_valid),
      .evt_clr        (evt_clr),
`ifdef PUSHBUTTON_IRQ_EN
      .irq_mask       (irq_mask),
`endif
      .btn_level      (btn_level),
      .btn_rise       (btn_rise),
      .btn_fall       (btn_fall),
      .evt_status     (evt_status),
      .irq            (irq)
   );

   typedef struct {
      int         n;
      logic [3:0] btn;
      logic       cv;
      logic [3:0] clr;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] st;
   } vec_t;

   vec_t tv[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge tb_ACLK);
      #1;
   endtask

   initial begin
      int early;
      tv[0]  = '{6, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tv[1]  = '{1, 4'b0001, 1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
      tv[2]  = '{1, 4'b0001, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
      tv[3]  = '{6, 4'b1001, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
      tv[4]  = '{1, 4'b1001, 1'b0, 4'b0000, 4'b1001, 4'b1000, 4'b0000, 4'b0001};
      tv[5]  = '{1, 4'b1001, 1'b0, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1001};
      tv[6]  = '{6, 4'b1101, 1'b0, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1001};
      tv[7]  = '{1, 4'b1101, 1'b0, 4'b0000, 4'b1101, 4'b0100, 4'b0000, 4'b1001};
      tv[8]  = '{1, 4'b1101, 1'b1, 4'b0100, 4'b1101, 4'b0000, 4'b0000, 4'b1101};
      tv[9]  = '{1, 4'b1101, 1'b1, 4'b0100, 4'b1101, 4'b0000, 4'b0000, 4'b1001};
      tv[10] = '{1, 4'b1101, 1'b0, 4'b1111, 4'b1101, 4'b0000, 4'b0000, 4'b1001};
      tv[11] = '{1, 4'b1101, 1'b1, 4'b0001, 4'b1101, 4'b0000, 4'b0000, 4'b1000};
      tv[12] = '{6, 4'b0101, 1'b0, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b1000};
      tv[13] = '{1, 4'b0101, 1'b0, 4'b0000, 4'b0101, 4'b0000, 4'b1000, 4'b1000};
      tv[14] = '{1, 4'b0101, 1'b0, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b1000};

      rst_n = 1'b0;
      btn_in = '0;
      evt_clr_valid = 1'b0;
      evt_clr = '0;
      irq_mask = '0;
      step();
      step();
      chk("reset outputs", {btn_level, btn_rise, btn_fall, evt_status, irq}, 0);
      rst_n = 1'b1;

      for (int r = 0; r < 15; r++) begin
         for (int k = 0; k < tv[r].n; k++) begin
            btn_in = tv[r].btn;
            evt_clr_valid = tv[r].cv;
            evt_clr = tv[r].clr;
            step();
            chk($sformatf("row%0d.%0d level", r, k), btn_level, tv[r].lvl);
            chk($sformatf("row%0d.%0d rise", r, k), btn_rise, tv[r].rise);
            chk($sformatf("row%0d.%0d fall", r, k), btn_fall, tv[r].fall);
            chk($sformatf("row%0d.%0d status", r, k), evt_status, tv[r].st);
            chk($sformatf("row%0d.%0d irq", r, k), irq, 0);
         end
      end
      evt_clr_valid = 1'b0;
      evt_clr = '0;

      early = 0;
      for (int k = 0; k < 4; k++) begin
         btn_in = (k % 2 == 0) ? 4'b0111 : 4'b0101;
         repeat (2) begin
            step();
            if (btn_rise[1] || btn_level[1]) early++;
         end
      end
      btn_in = 4'b0111;
      repeat (6) begin
         step();
         if (btn_rise[1] || btn_level[1]) early++;
      end
      chk("bounce early activity", early, 0);
      step();
      chk("bounce rise", btn_rise[1], 1);
      chk("bounce level", btn_level[1], 1);

      btn_in = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      btn_in = 4'b0001;
      repeat (4) step();
      rst_n = 1'b0;
      #1;
      chk("mid reset async clear", {btn_level, btn_rise, btn_fall, evt_status, irq}, 0);
      step();
      step();
      chk("mid reset held", {btn_level, btn_rise, btn_fall, evt_status, irq}, 0);
      rst_n = 1'b1;
      early = 0;
      repeat (6) begin
         step();
         if (btn_rise != 0 || btn_fall != 0 || btn_level != 0) early++;
      end
      chk("post reset no pulse", early, 0);
      step();
      chk("post reset rise", btn_rise, 4'b0001);
      chk("post reset level", btn_level, 4'b0001);
      step();
      chk("post reset status", evt_status, 4'b0001);

`ifdef PUSHBUTTON_IRQ_EN
      irq_mask = 4'b0010;
      step();
      step();
      chk("irq masked btn0", irq, 0);
      btn_in = 4'b0011;
      early = 0;
      for (int i = 0; i < 20 && !btn_rise[1]; i++) begin
         step();
         early++;
      end
      chk("irq btn1 rise seen", btn_rise[1], 1);
      chk("irq btn1 latency", early, 7);
      step();
      chk("irq status1 set", evt_status, 4'b0011);
      chk("irq not yet", irq, 0);
      step();
      chk("irq asserted", irq, 1);
      evt_clr_valid = 1'b1;
      evt_clr = 4'b0010;
      step();
      evt_clr_valid = 1'b0;
      evt_clr = '0;
      chk("irq status1 cleared", evt_status, 4'b0001);
      chk("irq still high", irq, 1);
      step();
      chk("irq dropped", irq, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
